// File: rtl/cal_lut_loader.sv
// Streams a 2**N_VDAC x N_LUT calibration table, highest entry first and MSB first,
// into a sensor shift register over a registered cal_clk / cal_dat serial link.
module cal_lut_loader #(
  parameter int N_VDAC  = 7,
  parameter int N_LUT   = 7,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              entry_req,
  output logic [N_VDAC-1:0] entry_idx,
  input  logic              entry_ack,
  input  logic [N_LUT-1:0]  entry_data,
  output logic              cal_clk,
  output logic              cal_dat,
  output logic              cal_ena,
  output logic              busy,
  output logic              done
);

  localparam int BW = (N_LUT > 1) ? $clog2(N_LUT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, FIN} state_t;

  state_t            state, state_nxt;
  logic [N_VDAC-1:0] idx_nxt;
  logic [N_LUT-1:0]  sreg, sreg_nxt, sreg_sh;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [7:0]        div_cnt, div_nxt;
  logic              clk_nxt, dat_nxt, ena_nxt, done_nxt;
  logic              div_last;

  assign entry_req = (state == FETCH);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = entry_idx;
    sreg_nxt  = sreg;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt;
    clk_nxt   = 1'b0;
    dat_nxt   = cal_dat;
    ena_nxt   = cal_ena;
    done_nxt  = 1'b0;
    sreg_sh   = sreg << 1;
    div_last  = (div_cnt == 8'(CLK_DIV - 1));

    case (state)
      IDLE: begin
        if (abort) begin
          ena_nxt = 1'b0;
        end else if (start) begin
          idx_nxt   = '1;
          ena_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (entry_ack) begin
          sreg_nxt  = entry_data;
          bit_nxt   = '0;
          div_nxt   = '0;
          dat_nxt   = entry_data[N_LUT-1];
          state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_nxt   = '0;
          clk_nxt   = 1'b1;
          state_nxt = SHIFT_HI;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      SHIFT_HI: begin
        clk_nxt = 1'b1;
        if (div_last) begin
          div_nxt  = '0;
          clk_nxt  = 1'b0;
          sreg_nxt = sreg_sh;
          bit_nxt  = bit_cnt + BW'(1);
          if (bit_cnt != BW'(N_LUT - 1)) begin
            // next bit is presented while cal_clk is low
            dat_nxt   = sreg_sh[N_LUT-1];
            state_nxt = SHIFT_LO;
          end else if (entry_idx != '0) begin
            idx_nxt   = entry_idx - N_VDAC'(1);
            state_nxt = FETCH;
          end else begin
            state_nxt = FIN;
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      FIN: begin
        done_nxt  = 1'b1;
        ena_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // abort outranks ack and counter expiry
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      clk_nxt   = 1'b0;
      dat_nxt   = 1'b0;
      ena_nxt   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      entry_idx <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      cal_clk   <= 1'b0;
      cal_dat   <= 1'b0;
      cal_ena   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      entry_idx <= idx_nxt;
      sreg      <= sreg_nxt;
      bit_cnt   <= bit_nxt;
      div_cnt   <= div_nxt;
      cal_clk   <= clk_nxt;
      cal_dat   <= dat_nxt;
      cal_ena   <= ena_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cal_lut_loader.sv
// Directed sequence with random tables/ack delays; a model receiver rebuilds the
// serial stream and compares it with the table that the source served.
module tb_cal_lut_loader;

  localparam int NE = 128;
  localparam int NB = NE * 7;

  logic       clk = 1'b0;
  logic       reset, start, abort, mon_clr;
  logic       entry_req, entry_ack, cal_clk, cal_dat, cal_ena, busy, done;
  logic [6:0] entry_idx, entry_data;
  logic       start_b, abort_b;
  logic       entry_req_b, cal_clk_b, cal_dat_b, cal_ena_b, busy_b, done_b;
  logic [6:0] entry_idx_b;

  logic [6:0] lut [0:NE-1];
  int         dly_tab [0:NE-1];
  int         wait_cnt;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  cal_lut_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .entry_req(entry_req), .entry_idx(entry_idx), .entry_ack(entry_ack),
    .entry_data(entry_data), .cal_clk(cal_clk), .cal_dat(cal_dat),
    .cal_ena(cal_ena), .busy(busy), .done(done)
  );

  cal_lut_loader #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .entry_req(entry_req_b), .entry_idx(entry_idx_b), .entry_ack(entry_req_b),
    .entry_data(7'h55), .cal_clk(cal_clk_b), .cal_dat(cal_dat_b),
    .cal_ena(cal_ena_b), .busy(busy_b), .done(done_b)
  );

  // table source: ack after dly_tab[idx] cycles of request
  assign entry_data = lut[entry_idx];
  assign entry_ack  = entry_req && (wait_cnt >= dly_tab[entry_idx]);
  always @(posedge clk) wait_cnt <= (entry_req && !entry_ack) ? wait_cnt + 1 : 0;

  // receiver model and protocol monitors
  logic [NB-1:0] rx, rx_b;
  logic          pclk, pdat, pclk_b, pdat_b;
  int rises, datviol, req127, clkfetch, dones;
  int rises_b, datviol_b, gap_b, g2_b, g3_b, hilong_b;

  always @(negedge clk) begin
    if (mon_clr) begin
      rises <= 0; rx <= '0; datviol <= 0; req127 <= 0; clkfetch <= 0; dones <= 0;
      rises_b <= 0; rx_b <= '0; datviol_b <= 0; gap_b <= 0; g2_b <= 0; g3_b <= 0;
      hilong_b <= 0;
    end else begin
      if (cal_clk && !pclk) begin
        rises <= rises + 1;
        rx    <= {rx[NB-2:0], cal_dat};
      end
      if (cal_clk && cal_dat !== pdat) datviol <= datviol + 1;
      if (entry_req && entry_idx == 7'd127) req127 <= req127 + 1;
      if (entry_req && cal_clk) clkfetch <= clkfetch + 1;
      if (done) dones <= dones + 1;
      if (cal_clk_b && !pclk_b) begin
        rises_b <= rises_b + 1;
        rx_b    <= {rx_b[NB-2:0], cal_dat_b};
        gap_b   <= 1;
        if (rises_b > 0 && gap_b == 2) g2_b <= g2_b + 1;
        if (rises_b > 0 && gap_b == 3) g3_b <= g3_b + 1;
      end else begin
        gap_b <= gap_b + 1;
      end
      if (cal_clk_b && cal_dat_b !== pdat_b) datviol_b <= datviol_b + 1;
      if (cal_clk_b && pclk_b) hilong_b <= hilong_b + 1;
    end
    pclk <= cal_clk; pdat <= cal_dat; pclk_b <= cal_clk_b; pdat_b <= cal_dat_b;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  function automatic int rx_bad();
    int bad = 0;
    for (int i = 0; i < NE; i++) if (rx[7*i +: 7] !== lut[i]) bad++;
    return bad;
  endfunction

  task automatic run_load(input int exp_cyc, input bit repulse, input string tag);
    int cyc = 0;
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    while (done !== 1'b1 && cyc < 6000) begin
      start = repulse && (cyc == 1000);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycles"}, cyc, exp_cyc);
    chk({tag, "_cal_ena"}, cal_ena, 1);
    tick();
    chk({tag, "_done_pulse_width"}, done, 0);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_cal_clk_rises"}, rises, NB);
    chk({tag, "_bad_entries"}, rx_bad(), 0);
    chk({tag, "_dat_change_while_clk_hi"}, datviol, 0);
  endtask

  function automatic int delay_sum();
    int s = 0;
    for (int i = 0; i < NE; i++) s += dly_tab[i];
    return s;
  endfunction

  initial begin
    int cyc, r, bad;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mon_clr = 1'b1;
    start_b = 1'b0; abort_b = 1'b0;
    for (int i = 0; i < NE; i++) begin lut[i] = 7'(i); dly_tab[i] = 0; end
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_cal_clk", cal_clk, 0);
    chk("rst_cal_dat", cal_dat, 0);
    chk("rst_cal_ena", cal_ena, 0);
    chk("rst_entry_req", entry_req, 0);
    chk("rst_entry_idx", entry_idx, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // CLK_DIV=1 instance, constant 0x55 entries
    clear_mon();
    start_b = 1'b1; tick(); start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 6000) begin tick(); cyc++; end
    chk("div1_done_cycles", cyc, NE * 15 + 1);
    tick();
    chk("div1_rises", rises_b, NB);
    chk("div1_period2_count", g2_b, NE * 6);
    chk("div1_entry_gap3_count", g3_b, NE - 1);
    chk("div1_clk_high_over_1", hilong_b, 0);
    chk("div1_dat_change_while_clk_hi", datviol_b, 0);
    bad = 0;
    for (int i = 0; i < NE; i++) if (rx_b[7*i +: 7] !== 7'b1010101) bad++;
    chk("div1_bad_entries", bad, 0);
    chk("div1_cal_ena", cal_ena_b, 1);

    // identity table, immediate ack
    run_load(NE * 29 + 1, 1'b0, "ident");

    // start with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_req", entry_req, 0);
    chk("start_abort_ena", cal_ena, 0);
    tick();
    chk("start_abort_still_idle", busy, 0);

    // random table, 5-cycle late ack on entry 127, start re-pulsed mid-load
    for (int i = 0; i < NE; i++) lut[i] = 7'($urandom);
    dly_tab[127] = 5;
    run_load(NE * 29 + 1 + 5, 1'b1, "late127");
    chk("late127_req_cycles", req127, 6);
    chk("late127_clk_in_fetch", clkfetch, 0);

    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_ena", cal_ena, 0);

    // abort after the 300th rise
    for (int i = 0; i < NE; i++) begin lut[i] = 7'($urandom); dly_tab[i] = 0; end
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (rises < 300 && cyc < 5000) begin tick(); cyc++; end
    chk("abort_reached_300", rises, 300);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cal_clk", cal_clk, 0);
    chk("abort_cal_dat", cal_dat, 0);
    chk("abort_cal_ena", cal_ena, 0);
    chk("abort_entry_req", entry_req, 0);
    repeat (50) tick();
    chk("abort_no_done", dones, 0);
    chk("abort_no_more_rises", rises, 300);

    // async reset while cal_clk is high, then a fresh load
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!(cal_clk === 1'b1 && cyc >= 200) && cyc < 2000) begin tick(); cyc++; end
    chk("rst_mid_found_shift_hi", cal_clk, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_cal_clk", cal_clk, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_entry_req", entry_req, 0);
    #1 reset = 1'b0;
    r = rises;
    repeat (20) tick();
    chk("rst_mid_no_rises", rises, r);
    chk("rst_mid_idle", busy, 0);
    for (int i = 0; i < NE; i++) begin
      lut[i] = 7'($urandom);
      dly_tab[i] = int'($urandom_range(0, 3));
    end
    run_load(NE * 29 + 1 + delay_sum(), 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
